// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one shared memory port between an instruction-fetch
//               requester and a data load/store requester. Data normally wins
//               ties. A saturating starvation counter hands the port to fetch
//               once data has won STARVE_LIMIT consecutive grants while fetch
//               was waiting.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               if_req/if_addr      - fetch request and address
//               if_ack/if_rdata     - fetch completion pulse and read data
//               d_req/d_we/d_addr/  - data request, store flag, address and
//               d_wdata               store data
//               d_ack/d_rdata       - data completion pulse and read data
//               mem_req/mem_we/     - shared memory request, driven only from
//               mem_addr/mem_wdata    the registers latched at grant time
//               mem_ack/mem_rdata   - memory completion pulse and read data
//               grant               - 00 idle, 01 fetch owns, 10 data owns
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant
);

  // State encoding doubles as the grant debug code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

  state_t                state_q,      state_d;
  logic [2:0]            starve_cnt_q, starve_cnt_d;
  logic                  if_ack_q,     if_ack_d;
  logic                  d_ack_q,      d_ack_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,   if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,    d_rdata_d;
  logic                  mem_we_q,     mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;

  // A request whose ack is high this cycle has just completed; the requester
  // only drops it after seeing the ack, so it must not be granted again.
  logic w_if_elig;
  logic w_d_elig;
  logic w_starved;

  assign w_if_elig = if_req && !if_ack_q;
  assign w_d_elig  = d_req  && !d_ack_q;
  assign w_starved = (starve_cnt_q == c_starve_limit);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        // mem_ack seen here is stale or spurious and is deliberately ignored.
        if (w_d_elig && !(w_if_elig && w_starved)) begin
          state_d     = BUSY_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Count only grants that make a waiting fetch wait longer.
          if (if_req) begin
            if (!w_starved) begin
              starve_cnt_d = starve_cnt_q + 3'd1;
            end
          end else begin
            starve_cnt_d = 3'd0;
          end
        end else if (w_if_elig) begin
          state_d      = BUSY_I;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = 3'd0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d    = IDLE;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign grant     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Expected grants are
//               queued as stimulus is issued; a monitor pops them when
//               mem_req rises and queues the expected read data per port,
//               which is popped when the matching ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, mem_ack;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  logic        model_ack, spur_ack;
  logic [31:0] model_rdata, spur_rdata;
  int          mem_lat;

  exp_t        exp_q[$];
  logic [31:0] ack_iq[$];
  logic [31:0] ack_dq[$];
  logic [31:0] last_i, last_d;
  int          n_iack, n_dack;
  int          n_checks = 0;
  int          n_errors = 0;

  assign mem_ack   = model_ack | spur_ack;
  assign mem_rdata = spur_ack ? spur_rdata : model_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00A00513 : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [1:0] p, input logic [31:0] a,
                          input logic we, input logic [31:0] wd);
    exp_t e;
    e.port = p; e.addr = a; e.we = we; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic fetch_req(input logic [31:0] a, output int cyc);
    if_req = 1'b1; if_addr = a; cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); cyc++;
      if (if_ack) break;
    end
    if (!if_ack) chk("fetch_timeout", if_ack, 1);
    if_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); cyc++;
      if (d_ack) break;
    end
    if (!d_ack) chk("data_timeout", d_ack, 1);
    d_req = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (grant == g) break;
    end
    if (grant != g) chk("grant_timeout", grant, g);
  endtask

  // Memory model: acks mem_lat cycles after the first mem_req cycle.
  initial begin
    int lat_cnt;
    model_ack = 1'b0; model_rdata = '0; lat_cnt = 0;
    forever begin
      @(posedge clk); #1;
      model_ack = 1'b0;
      if (mem_req && !rst) begin
        if (lat_cnt >= mem_lat) begin
          model_ack   = 1'b1;
          model_rdata = mem_fn(mem_addr);
          lat_cnt     = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_req, prev_iack, prev_dack;
    logic [31:0] cap_addr, cap_wdata, v;
    logic        cap_we;
    exp_t        e;
    prev_req = 0; prev_iack = 0; prev_dack = 0;
    cap_addr = '0; cap_wdata = '0; cap_we = 0;
    last_i = '0; last_d = '0; n_iack = 0; n_dack = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_iq.delete(); ack_dq.delete();
        last_i = '0; last_d = '0;
        prev_req = 0; prev_iack = 0; prev_dack = 0;
      end else begin
        chk("mem_req_vs_grant", mem_req, grant != 2'b00);
        if (mem_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            chk("grant_unexpected", mem_req, 0);
          end else begin
            e = exp_q.pop_front();
            chk("grant", grant, e.port);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            if (e.port == 2'b01) ack_iq.push_back(mem_fn(e.addr));
            else                 ack_dq.push_back(mem_fn(e.addr));
          end
        end else if (mem_req) begin
          chk("mem_addr_stable", mem_addr, cap_addr);
          chk("mem_we_stable", mem_we, cap_we);
          chk("mem_wdata_stable", mem_wdata, cap_wdata);
        end
        if (if_ack || d_ack) chk("ack_exclusive", if_ack & d_ack, 0);
        if (if_ack) begin
          n_iack++;
          chk("if_ack_pulse", prev_iack, 0);
          if (ack_iq.size() == 0) chk("if_ack_unexpected", if_ack, 0);
          else begin
            v = ack_iq.pop_front();
            chk("if_rdata", if_rdata, v);
            last_i = v;
          end
        end else begin
          chk("if_rdata_hold", if_rdata, last_i);
        end
        if (d_ack) begin
          n_dack++;
          chk("d_ack_pulse", prev_dack, 0);
          if (ack_dq.size() == 0) chk("d_ack_unexpected", d_ack, 0);
          else begin
            v = ack_dq.pop_front();
            chk("d_rdata", d_rdata, v);
            last_d = v;
          end
        end else begin
          chk("d_rdata_hold", d_rdata, last_d);
        end
        prev_req = mem_req; prev_iack = if_ack; prev_dack = d_ack;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus.
  initial begin
    int c1, c2, snap_i, snap_d;
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    spur_ack = 0; spur_rdata = '0; mem_lat = 0;
    tick(3);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    tick(1); rst = 1'b0;

    // Lone fetch, memory answers in the second mem_req cycle.
    tick(1); mem_lat = 1;
    exp_push(2'b01, 32'h10, 1'b0, '0);
    fetch_req(32'h10, c1);
    chk("lone_fetch_latency", c1, 4);
    tick(3);
    chk("lone_fetch_rdata_held", if_rdata, 32'h00A00513);

    // Minimum latency: ack on the third cycle after the request.
    mem_lat = 0;
    exp_push(2'b01, 32'h30, 1'b0, '0);
    fetch_req(32'h30, c1);
    chk("min_latency", c1, 3);

    // Simultaneous: data first, fetch on the following IDLE cycle.
    tick(1);
    exp_push(2'b10, 32'h40, 1'b0, '0);
    exp_push(2'b01, 32'h20, 1'b0, '0);
    fork
      fetch_req(32'h20, c1);
      data_req(1'b0, 32'h40, '0, c2);
    join
    chk("simul_data_latency", c2, 3);
    chk("simul_fetch_latency", c1, 5);

    // Store with requester inputs changing mid-transaction.
    tick(1); mem_lat = 3;
    exp_push(2'b10, 32'h100, 1'b1, 32'hDEADBEEF);
    fork
      data_req(1'b1, 32'h100, 32'hDEADBEEF, c2);
      begin
        wait_grant(2'b10);
        @(negedge clk);
        d_addr = 32'h200; d_wdata = 32'h12345678;
      end
    join
    chk("store_latency", c2, 6);

    // Starvation: fetch waits through four data grants, then wins.
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      exp_push(2'b10, 32'h400 + 32'(i * 4), 1'b0, '0);
      if_req = 1'b1; if_addr = 32'h80;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400 + 32'(i * 4);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (d_ack) break;
      end
      chk("starve_data_ack", d_ack, 1);
      d_req = 1'b0; if_req = 1'b0;
    end
    tick(1);
    exp_push(2'b01, 32'h80, 1'b0, '0);
    exp_push(2'b10, 32'h500, 1'b0, '0);
    fork
      fetch_req(32'h80, c1);
      data_req(1'b0, 32'h500, '0, c2);
    join
    chk("starve_fetch_latency", c1, 3);

    // Spurious mem_ack in IDLE.
    tick(2);
    snap_i = n_iack; snap_d = n_dack;
    spur_rdata = 32'hFFFF0000; spur_ack = 1'b1;
    tick(1); spur_ack = 1'b0;
    @(negedge clk);
    chk("spur_grant", grant, 0);
    tick(1);
    @(negedge clk);
    chk("spur_grant_later", grant, 0);
    chk("spur_no_iack", n_iack - snap_i, 0);
    chk("spur_no_dack", n_dack - snap_d, 0);
    chk("spur_if_rdata", if_rdata, mem_fn(32'h80));
    chk("spur_d_rdata", d_rdata, mem_fn(32'h500));

    // Reset while data owns the port, then a late mem_ack.
    tick(1); mem_lat = 20;
    exp_push(2'b10, 32'h600, 1'b0, '0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    wait_grant(2'b10);
    tick(1);
    snap_d = n_dack;
    rst = 1'b1; d_req = 1'b0;
    tick(1);
    rst = 1'b0; spur_rdata = 32'h0BAD0BAD; spur_ack = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", mem_req, 0);
    tick(1); spur_ack = 1'b0;
    @(negedge clk);
    chk("abort_grant", grant, 0);
    chk("abort_mem_req_late", mem_req, 0);
    tick(3);
    chk("abort_no_dack", n_dack - snap_d, 0);
    chk("abort_d_rdata", d_rdata, 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
